// File: rtl/monitor_symbol_feeder.sv
// Purpose: transmit side of the runtime-monitor symbol interface; queues core event symbols and drives symbols/run/mon_reset.
// Latency: event sampled in cycle N while streaming from an empty FIFO appears on symbols with run=1 in cycle N+2.
// Backpressure: none from the monitor; a full FIFO with no pop drops the event and records it in overflow/drop_count.
// Optional build macro: MON_FEED_IDLE_SYM_EN (emit IDLE_SYMBOL with run=1 whenever streaming with nothing queued).
module monitor_symbol_feeder #(
  parameter int         DEPTH          = 8,
  parameter int         MON_RST_CYCLES = 2,
  parameter logic [7:0] SOT_SYMBOL     = 8'hFF,
  parameter logic [7:0] IDLE_SYMBOL    = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        evt_valid,
  input  logic [7:0]  evt_symbol,
  output logic [7:0]  symbols,
  output logic        run,
  output logic        mon_reset,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MON_RST_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MON_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_START,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    symbols_q, symbols_d;
  logic          run_q, run_d;
  logic          mon_reset_q, mon_reset_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_count_q, drop_count_d;

  logic fifo_empty;
  logic fifo_full;
  logic enter_reset;
  logic accepting;
  logic pop;
  logic push_ok;
  logic drop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // State register and reset-hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: trace start sequencing, streaming and drain on disable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_RESET;
          cnt_d   = '0;
        end
      end
      S_RESET: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_START: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (!enable) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (enable) begin
          state_d = S_RESET;
          cnt_d   = '0;
        end else if (fifo_empty) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output and FIFO control: decide pop/push/drop and the next registered outputs.
  always_comb begin
    enter_reset = (state_d == S_RESET) && (state_q != S_RESET);
    accepting   = (state_q != S_IDLE) && !enter_reset;
    // Pop only looks at the registered pointers, so a same-cycle write is never bypassed.
    pop         = ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                  !fifo_empty && !enter_reset;
    push_ok     = evt_valid && accepting && (!fifo_full || pop);
    drop        = evt_valid && accepting && fifo_full && !pop;

    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    overflow_d   = overflow_q | drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end

    // A new trace starts from a clean FIFO and clean error status.
    if (enter_reset) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end

    mon_reset_d = (state_d == S_RESET);
    run_d       = 1'b0;
    symbols_d   = symbols_q;
    if (state_d == S_START) begin
      run_d     = 1'b1;
      symbols_d = SOT_SYMBOL;
    end else if (pop) begin
      run_d     = 1'b1;
      symbols_d = mem_q[rd_ptr_q[AW-1:0]];
    end
`ifdef MON_FEED_IDLE_SYM_EN
    else if ((state_d == S_STREAM) || (state_d == S_DRAIN)) begin
      // Keep the monitor's time base continuous while nothing is queued.
      run_d     = 1'b1;
      symbols_d = IDLE_SYMBOL;
    end
`endif
  end

`ifndef MON_FEED_IDLE_SYM_EN
  logic unused_idle_sym;
  assign unused_idle_sym = ^IDLE_SYMBOL;
`endif

  // Registered outputs, FIFO pointers and drop accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      symbols_q    <= 8'h00;
      run_q        <= 1'b0;
      mon_reset_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      symbols_q    <= symbols_d;
      run_q        <= run_d;
      mon_reset_q  <= mon_reset_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // FIFO storage write; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= evt_symbol;
    end
  end

  assign symbols    = symbols_q;
  assign run        = run_q;
  assign mon_reset  = mon_reset_q;
  assign busy       = (state_q != S_IDLE);
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_monitor_symbol_feeder.sv
// Directed bench for monitor_symbol_feeder: start-up sequence, streaming latency,
// overflow/no-drop boundaries, drain on disable and reset mid-stream.
// u_dut uses default parameters; u_dut_long holds monitor reset long enough to fill the FIFO.
module tb_monitor_symbol_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        evt_valid;
  logic [7:0]  evt_symbol;

  logic [7:0]  a_symbols, b_symbols;
  logic        a_run, b_run;
  logic        a_mon_reset, b_mon_reset;
  logic        a_busy, b_busy;
  logic        a_overflow, b_overflow;
  logic [15:0] a_drop_count, b_drop_count;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] sym_a [1:9];

  always #5 clk = ~clk;

  monitor_symbol_feeder u_dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .evt_valid  (evt_valid),
    .evt_symbol (evt_symbol),
    .symbols    (a_symbols),
    .run        (a_run),
    .mon_reset  (a_mon_reset),
    .busy       (a_busy),
    .overflow   (a_overflow),
    .drop_count (a_drop_count)
  );

  monitor_symbol_feeder #(.MON_RST_CYCLES(12)) u_dut_long (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .evt_valid  (evt_valid),
    .evt_symbol (evt_symbol),
    .symbols    (b_symbols),
    .run        (b_run),
    .mon_reset  (b_mon_reset),
    .busy       (b_busy),
    .overflow   (b_overflow),
    .drop_count (b_drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_evt(input logic v, input logic [7:0] s);
    evt_valid  = v;
    evt_symbol = s;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    set_evt(1'b0, 8'h00);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    sym_a = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h33};

    // Reset state
    do_reset();
    chk("rst symbols",    {24'd0, a_symbols}, 32'h00);
    chk("rst run",        {31'd0, a_run}, 32'd0);
    chk("rst mon_reset",  {31'd0, a_mon_reset}, 32'd0);
    chk("rst busy",       {31'd0, a_busy}, 32'd0);
    chk("rst overflow",   {31'd0, a_overflow}, 32'd0);
    chk("rst drop_count", {16'd0, a_drop_count}, 32'd0);

    // Start-up and 3-event stream on the default instance
    enable = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      if (t - 1 == 4)      set_evt(1'b1, 8'h11);
      else if (t - 1 == 5) set_evt(1'b1, 8'h22);
      else if (t - 1 == 6) set_evt(1'b1, 8'h33);
      else                 set_evt(1'b0, 8'h00);
      tick();
      chk($sformatf("A run t%0d", t), {31'd0, a_run}, {31'd0, (t == 3) || (t >= 6 && t <= 8)});
      chk($sformatf("A symbols t%0d", t), {24'd0, a_symbols}, {24'd0, sym_a[t]});
      chk($sformatf("A mon_reset t%0d", t), {31'd0, a_mon_reset}, {31'd0, t <= 2});
    end

    // Fill to full while held in monitor reset, drop 3, then push alongside pops
    do_reset();
    chk("B rst busy", {31'd0, b_busy}, 32'd0);
    enable = 1'b1;
    for (int t = 1; t <= 26; t++) begin
      int c;
      c = t - 1;
      if (c >= 1 && c <= 8)        set_evt(1'b1, 8'(8'hA0 + c));
      else if (c >= 9 && c <= 11)  set_evt(1'b1, 8'(8'hB0 + c - 8));
      else if (c >= 14 && c <= 16) set_evt(1'b1, 8'(8'hC0 + c - 13));
      else                         set_evt(1'b0, 8'h00);
      tick();
      chk($sformatf("B run t%0d", t), {31'd0, b_run}, {31'd0, (t == 13) || (t >= 15 && t <= 25)});
      chk($sformatf("B mon_reset t%0d", t), {31'd0, b_mon_reset}, {31'd0, t <= 12});
      if (t == 13) chk("B sot", {24'd0, b_symbols}, 32'hFF);
      if (t >= 15 && t <= 22) chk($sformatf("B sym t%0d", t), {24'd0, b_symbols}, 32'(8'hA0 + t - 14));
      if (t >= 23 && t <= 25) chk($sformatf("B sym t%0d", t), {24'd0, b_symbols}, 32'(8'hC0 + t - 22));
      if (t == 9) begin
        chk("B overflow before drop", {31'd0, b_overflow}, 32'd0);
        chk("B drops before drop", {16'd0, b_drop_count}, 32'd0);
      end
      if (t == 12 || t == 26) begin
        chk($sformatf("B overflow t%0d", t), {31'd0, b_overflow}, 32'd1);
        chk($sformatf("B drop_count t%0d", t), {16'd0, b_drop_count}, 32'd3);
      end
    end

    // Drain: disable with 4 entries queued
    do_reset();
    enable = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      int c;
      c = t - 1;
      if (c >= 1 && c <= 4) set_evt(1'b1, 8'(8'hD0 + c));
      else                  set_evt(1'b0, 8'h00);
      if (c == 14) enable = 1'b0;
      tick();
      if (t >= 13) begin
        chk($sformatf("C run t%0d", t), {31'd0, b_run}, {31'd0, (t == 13) || (t >= 15 && t <= 18)});
        chk($sformatf("C busy t%0d", t), {31'd0, b_busy}, {31'd0, t <= 18});
      end
      if (t >= 15 && t <= 18) chk($sformatf("C sym t%0d", t), {24'd0, b_symbols}, 32'(8'hD0 + t - 14));
    end

    // Reset mid-stream with 5 entries queued, then a fresh trace
    do_reset();
    enable = 1'b1;
    for (int t = 1; t <= 32; t++) begin
      int c;
      c = t - 1;
      if (c >= 1 && c <= 5) set_evt(1'b1, 8'(8'hE0 + c));
      else                  set_evt(1'b0, 8'h00);
      reset = (c == 14);
      tick();
      if (t == 15) begin
        chk("D run after reset",     {31'd0, b_run}, 32'd0);
        chk("D symbols after reset", {24'd0, b_symbols}, 32'h00);
        chk("D busy after reset",    {31'd0, b_busy}, 32'd0);
        chk("D mon_reset on reset",  {31'd0, b_mon_reset}, 32'd0);
      end
      if (t >= 16) begin
        chk($sformatf("D run t%0d", t), {31'd0, b_run}, {31'd0, t == 28});
        chk($sformatf("D mon_reset t%0d", t), {31'd0, b_mon_reset}, {31'd0, t <= 27});
        chk($sformatf("D symbols t%0d", t), {24'd0, b_symbols}, (t >= 28) ? 32'hFF : 32'h00);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
